alien_fire_scheduler: RTL and testbench



---
 rtl/spinv_pkg.sv | 21 ++
 rtl/rr_pick15.sv | 30 +++
 rtl/alien_fire_scheduler.sv | 147 ++++++++++++++
 tb/tb_alien_fire_scheduler.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/spinv_pkg.sv
// rtl/spinv_pkg.sv - shared types and helpers for the space-invaders game blocks
package spinv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_GRANT = 2'd2,
      ST_FLY   = 2'd3
   } fire_state_t;

   localparam int NUM_ALIENS     = 15;
   localparam int ALIENS_PER_ROW = 5;

   localparam logic [9:0] PARK_X = 10'd0;
   localparam logic [9:0] PARK_Y = 10'h3FF;

   function automatic logic [1:0] row_of(input logic [3:0] id);
      return 2'(id / 4'(ALIENS_PER_ROW));
   endfunction

endpackage

// File: rtl/rr_pick15.sv
// rtl/rr_pick15.sv - combinational round-robin picker over 15 requesters
import spinv_pkg::*;

module rr_pick15 (
   input  logic [14:0] req,
   input  logic [3:0]  last,
   output logic [3:0]  grant_id,
   output logic        any
);

   logic w_found;
   int   w_idx;

   // Scan starts one past last and wraps, so last itself is the final candidate.
   always_comb begin
      grant_id = '0;
      w_found  = 1'b0;
      w_idx    = 0;
      for (int k = 1; k <= NUM_ALIENS; k++) begin
         w_idx = (int'(last) + k) % NUM_ALIENS;
         if (!w_found && req[w_idx]) begin
            w_found  = 1'b1;
            grant_id = 4'(w_idx);
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/alien_fire_scheduler.sv
// rtl/alien_fire_scheduler.sv - round-robin alien return-fire scheduler
import spinv_pkg::*;

module alien_fire_scheduler #(
   parameter int FIRE_INTERVAL = 24,
   parameter int SHOT_STEP     = 8,
   parameter int PLAYER_Y      = 425,
   parameter int PLAYER_HALF_W = 20,
   parameter int PLAYER_HALF_H = 10,
   parameter int ALIEN_HALF_H  = 10,
   parameter int SCREEN_BOTTOM = 479
) (
   input  logic         Clk,
   input  logic         reset,
   input  logic         enable,
   input  logic [14:0]  alive,
   input  logic [149:0] alien_x_flat,
   input  logic [29:0]  row_y_flat,
   input  logic [9:0]   player_x,
   output logic [9:0]   returnX,
   output logic [9:0]   returnY,
   output logic         shot_active,
   output logic [3:0]   shooter_id,
   output logic         player_hit
);

   localparam int CNT_W = (FIRE_INTERVAL > 1) ? $clog2(FIRE_INTERVAL + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FIRE_INTERVAL - 1);
   localparam logic [10:0] HW11  = 11'(PLAYER_HALF_W);
   localparam logic [10:0] YLO11 = 11'(PLAYER_Y - PLAYER_HALF_H);
   localparam logic [10:0] YHI11 = 11'(PLAYER_Y + PLAYER_HALF_H);
   localparam logic [10:0] STP11 = 11'(SHOT_STEP);
   localparam logic [10:0] BOT11 = 11'(SCREEN_BOTTOM);
   localparam logic [10:0] AHH11 = 11'(ALIEN_HALF_H);

   fire_state_t      r_state, w_state_n;
   logic [CNT_W-1:0] r_cnt, w_cnt_n;
   logic [9:0]       r_x, w_x_n, r_y, w_y_n;
   logic             r_act, w_act_n;
   logic [3:0]       r_sid, w_sid_n, r_last, w_last_n;
   logic             w_hit;

   logic [3:0]  w_grant;
   logic        w_any;
   logic [1:0]  w_row;
   logic [10:0] w_x11, w_y11, w_px11, w_spawn_y;
   logic        w_in_box, w_off_screen;

   rr_pick15 u_pick (
      .req      (alive),
      .last     (r_last),
      .grant_id (w_grant),
      .any      (w_any)
   );

   assign w_row     = row_of(w_grant);
   assign w_spawn_y = {1'b0, row_y_flat[int'(w_row)*10 +: 10]} + AHH11;

   assign w_x11  = {1'b0, r_x};
   assign w_y11  = {1'b0, r_y};
   assign w_px11 = {1'b0, player_x};
   assign w_in_box = (w_x11 + HW11 >= w_px11) && (w_x11 <= w_px11 + HW11) &&
                     (w_y11 >= YLO11) && (w_y11 <= YHI11);
   assign w_off_screen = (w_y11 + STP11 > BOT11);

   always_ff @(posedge Clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_x     <= PARK_X;
         r_y     <= PARK_Y;
         r_act   <= 1'b0;
         r_sid   <= 4'd0;
         r_last  <= 4'd14;
      end else begin
         r_state <= w_state_n;
         r_cnt   <= w_cnt_n;
         r_x     <= w_x_n;
         r_y     <= w_y_n;
         r_act   <= w_act_n;
         r_sid   <= w_sid_n;
         r_last  <= w_last_n;
      end
   end

   always_comb begin
      w_state_n = r_state;
      w_cnt_n   = r_cnt;
      w_x_n     = r_x;
      w_y_n     = r_y;
      w_act_n   = r_act;
      w_sid_n   = r_sid;
      w_last_n  = r_last;
      w_hit     = 1'b0;
      if (!enable) begin
         w_state_n = ST_IDLE;
         w_cnt_n   = '0;
         w_x_n     = PARK_X;
         w_y_n     = PARK_Y;
         w_act_n   = 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_state_n = ST_WAIT;
               w_cnt_n   = '0;
            end
            ST_WAIT: begin
               w_cnt_n = r_cnt + CNT_W'(1);
               if (r_cnt == CNT_LAST) w_state_n = ST_GRANT;
            end
            ST_GRANT: begin
               w_cnt_n   = '0;
               w_state_n = ST_WAIT;
               if (w_any) begin
                  w_x_n     = alien_x_flat[int'(w_grant)*10 +: 10];
                  w_y_n     = w_spawn_y[9:0];
                  w_act_n   = 1'b1;
                  w_sid_n   = w_grant;
                  w_last_n  = w_grant;
                  w_state_n = ST_FLY;
               end
            end
            ST_FLY: begin
               // A hit outranks leaving the screen on the same tick.
               if (w_in_box || w_off_screen) begin
                  w_hit     = w_in_box;
                  w_state_n = ST_WAIT;
                  w_cnt_n   = '0;
                  w_x_n     = PARK_X;
                  w_y_n     = PARK_Y;
                  w_act_n   = 1'b0;
               end else begin
                  w_y_n = 10'(w_y11 + STP11);
               end
            end
            default: w_state_n = ST_IDLE;
         endcase
      end
   end

   assign returnX     = r_x;
   assign returnY     = r_y;
   assign shot_active = r_act;
   assign shooter_id  = r_sid;
   assign player_hit  = w_hit;

endmodule

// File: tb/tb_alien_fire_scheduler.sv
// tb/tb_alien_fire_scheduler.sv - scoreboard bench for alien_fire_scheduler
import spinv_pkg::*;

module tb_alien_fire_scheduler;

   logic         Clk = 1'b0;
   logic         reset;
   logic         enable;
   logic [14:0]  alive;
   logic [149:0] alien_x_flat;
   logic [29:0]  row_y_flat;
   logic [9:0]   player_x;
   logic [9:0]   returnX, returnY;
   logic         shot_active, player_hit;
   logic [3:0]   shooter_id;

   alien_fire_scheduler #(.FIRE_INTERVAL(4)) dut (
      .Clk          (Clk),
      .reset        (reset),
      .enable       (enable),
      .alive        (alive),
      .alien_x_flat (alien_x_flat),
      .row_y_flat   (row_y_flat),
      .player_x     (player_x),
      .returnX      (returnX),
      .returnY      (returnY),
      .shot_active  (shot_active),
      .shooter_id   (shooter_id),
      .player_hit   (player_hit)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      int x;
      int y;
      int sid;
   } shot_t;

   shot_t q_shot[$];
   int    q_hit[$];
   int    q_land[$];
   int    n_checks = 0;
   int    n_fail   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic expect_shot(input int x, input int y, input int sid, input int land_y);
      shot_t s;
      s.x = x; s.y = y; s.sid = sid;
      q_shot.push_back(s);
      q_land.push_back(land_y);
   endtask

   // Wait (bounded) for shot_active to reach lvl, sampled on negedges.
   task automatic wait_act(input logic lvl, input int bound, input string name);
      int n = 0;
      while (shot_active !== lvl && n < bound) begin
         @(negedge Clk);
         n++;
      end
      if (shot_active !== lvl) check({name, "_timeout"}, 0, 1);
   endtask

   task automatic wait_y(input int y, input int bound, input string name);
      int n = 0;
      while (!(shot_active === 1'b1 && int'(returnY) == y) && n < bound) begin
         @(negedge Clk);
         n++;
      end
      if (!(shot_active === 1'b1 && int'(returnY) == y)) check({name, "_timeout"}, 0, 1);
   endtask

   logic  m_prev_act = 1'b0;
   logic  m_prev_hit = 1'b0;
   int    m_prev_y   = 1023;
   shot_t m_s;
   int    m_v;

   // Monitor: new shots, per-tick step, hits and parking are checked against the queues.
   always @(negedge Clk) begin
      if (shot_active && !m_prev_act) begin
         if (q_shot.size() == 0) check("unexpected_shot", 1, 0);
         else begin
            m_s = q_shot.pop_front();
            check("spawn_x", int'(returnX), m_s.x);
            check("spawn_y", int'(returnY), m_s.y);
            check("shooter_id", int'(shooter_id), m_s.sid);
         end
      end else if (shot_active && m_prev_act) begin
         check("step_y", int'(returnY), m_prev_y + 8);
      end
      if (player_hit) begin
         if (m_prev_hit) check("hit_twice", 1, 0);
         check("hit_while_flying", int'(shot_active), 1);
         if (q_hit.size() == 0) check("unexpected_hit", 1, 0);
         else begin
            m_v = q_hit.pop_front();
            check("hit_y", int'(returnY), m_v);
         end
      end
      if (!shot_active && m_prev_act) begin
         if (q_land.size() == 0) check("unexpected_park", 1, 0);
         else begin
            m_v = q_land.pop_front();
            check("last_flight_y", m_prev_y, m_v);
            check("park_y", int'(returnY), 1023);
            check("park_x", int'(returnX), 0);
         end
      end
      m_prev_act = shot_active;
      m_prev_hit = player_hit;
      m_prev_y   = int'(returnY);
   end

   initial begin
      int lat;
      int bad;
      reset   = 1'b1;
      enable  = 1'b0;
      alive   = 15'h7FFF;
      player_x = 10'd300;
      for (int i = 0; i < 15; i++) alien_x_flat[i*10 +: 10] = 10'(300 + 20 * i);
      row_y_flat = {10'd200, 10'd150, 10'd100};

      repeat (3) @(negedge Clk);
      check("rst_returnX", int'(returnX), 0);
      check("rst_returnY", int'(returnY), 1023);
      check("rst_shot_active", int'(shot_active), 0);
      check("rst_shooter_id", int'(shooter_id), 0);
      check("rst_player_hit", int'(player_hit), 0);
      reset = 1'b0;

      // First shot from id 0 straight at the player.
      expect_shot(300, 110, 0, 422);
      q_hit.push_back(422);
      enable = 1'b1;
      lat = 0;
      while (!shot_active && lat < 20) begin
         @(negedge Clk);
         lat++;
      end
      check("first_shot_latency", lat, 4 + 2);
      wait_act(1'b0, 100, "hit_flight");

      // Player moved away: id 1 misses and flies to the bottom.
      player_x = 10'd100;
      expect_shot(320, 110, 1, 478);
      wait_act(1'b1, 50, "miss_spawn");
      wait_act(1'b0, 100, "miss_flight");

      // Only ids 2 and 5 alive: grants alternate.
      alive = 15'h0024;
      expect_shot(340, 110, 2, 478);
      expect_shot(400, 160, 5, 472);
      expect_shot(340, 110, 2, 478);
      expect_shot(400, 160, 5, 472);
      for (int k = 0; k < 4; k++) begin
         wait_act(1'b1, 50, "alt_spawn");
         wait_act(1'b0, 100, "alt_flight");
      end

      // No aliens alive: nothing is launched.
      alive = 15'h0000;
      bad = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge Clk);
         if (shot_active !== 1'b0 || returnY !== 10'h3FF) bad++;
      end
      check("dead_fleet_parked_ticks", bad, 0);

      // enable drop mid-flight.
      alive = 15'h7FFF;
      expect_shot(420, 160, 6, 200);
      wait_y(200, 100, "en_drop_reach");
      enable = 1'b0;
      @(negedge Clk);
      check("en_drop_state_idle", int'(dut.r_state), int'(ST_IDLE));
      check("en_drop_last_kept", int'(dut.r_last), 6);

      // reset mid-flight, then the round-robin restarts at id 0.
      enable = 1'b1;
      expect_shot(440, 160, 7, 200);
      wait_y(200, 100, "rst_drop_reach");
      reset = 1'b1;
      @(negedge Clk);
      check("mid_rst_returnX", int'(returnX), 0);
      check("mid_rst_returnY", int'(returnY), 1023);
      check("mid_rst_shot_active", int'(shot_active), 0);
      check("mid_rst_shooter_id", int'(shooter_id), 0);
      check("mid_rst_last_grant", int'(dut.r_last), 14);
      check("mid_rst_state_idle", int'(dut.r_state), int'(ST_IDLE));
      reset = 1'b0;
      expect_shot(300, 110, 0, 478);
      wait_act(1'b1, 50, "post_rst_spawn");
      wait_act(1'b0, 100, "post_rst_flight");

      @(negedge Clk);
      check("shot_queue_drained", q_shot.size(), 0);
      check("land_queue_drained", q_land.size(), 0);
      check("hit_queue_drained", q_hit.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
